global_buffer_bank: RTL

//   Parametrised successor to the single-port global buffer. Multi-lane on-chip buffer feeding the systolic array.
//   One write port and one read port per cycle; per-lane write mask; fixed read latency with a valid strobe.

---
 rtl/global_buffer_bank.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/global_buffer_bank.sv
// global_buffer_bank
//   Multi-lane on-chip buffer feeding the systolic array. One write port and
//   one read port per cycle, per-lane write mask, fixed read latency (1 or 2)
//   with a one-cycle valid strobe, and a built-in engine that zeroes the whole
//   array between layers.
//
//   Optional feature macro: GBUF_WR_BYPASS_EN
//     defined   -> a read that collides with a same-cycle write to the same
//                  word returns the merged (write-first) word.
//     undefined -> a colliding read returns the full old word (read-first).

module global_buffer_bank #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int LANES     = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_start,
    output logic                         busy,
    input  logic                         wr_en,
    input  logic [ADDR_BITS-1:0]         wr_idx,
    input  logic [LANES-1:0]             wr_mask,
    input  logic [LANES*DATA_BITS-1:0]   wr_data,
    input  logic                         rd_en,
    input  logic [ADDR_BITS-1:0]         rd_idx,
    output logic [LANES*DATA_BITS-1:0]   rd_data,
    output logic                         rd_valid
);

    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam int WORD_BITS = LANES * DATA_BITS;

    // Only two read latencies have an implementation; anything else is a build error.
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
        $error("global_buffer_bank: RD_LAT must be 1 or 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   clr_ptr;
    logic [WORD_BITS-1:0]   mem [DEPTH];

    logic                   wr_go;
    logic                   rd_go;
    logic                   clr_go;
    logic [WORD_BITS-1:0]   wr_word;
    logic [WORD_BITS-1:0]   rd_word;

    logic                   s1_valid;
    logic [WORD_BITS-1:0]   s1_data;

    // Host requests are honoured only while the clear engine is idle and not in reset.
    always_comb begin
        wr_go  = wr_en & ~busy & ~rst;
        rd_go  = rd_en & ~busy & ~rst;
        clr_go = clr_start & ~busy & ~rst;
    end

    // Merged write word: masked lanes take new data, the rest keep the stored value.
    always_comb begin
        wr_word = mem[wr_idx];
        for (int i = 0; i < LANES; i++) begin
            if (wr_mask[i]) begin
                wr_word[i*DATA_BITS +: DATA_BITS] = wr_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

`ifdef GBUF_WR_BYPASS_EN
    // Write-first collision: a same-word write is forwarded into the read data.
    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_go && (wr_idx == rd_idx)) begin
            rd_word = wr_word;
        end
    end
`else
    // Read-first: the read always sees the word as stored before this edge.
    always_comb begin
        rd_word = mem[rd_idx];
    end
`endif

    // Clear engine: one word zeroed per cycle, stops after the last address without wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_go) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_ptr <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_ptr == ADDR_BITS'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage update: the clear engine owns the array while running; reset leaves contents intact.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_go) begin
                mem[wr_idx] <= wr_word;
            end
        end
    end

    // First read stage: capture the word on an accepted read, hold it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_go;
            if (rd_go) begin
                s1_data <= rd_word;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic                 s2_valid;
        logic [WORD_BITS-1:0] s2_data;

        // Extra output stage; the valid bit travels with the data.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
    end else begin : g_lat1
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
    end

endmodule
